prbs_test_ctrl: RTL and testbench

Sequencing controller for the PRBS pattern-check datapath (byte assembler, PRBS-15 generator, pattern detector). It collects a 32-bit search pattern from a byte stream, holds the datapath in reset while the pattern settles, releases it for a bounded run, and reports pass/timeout/error with the detection latency. It replaces free-running datapath release with an explicit start/done test cycle.

---
 rtl/prbs_test_ctrl.sv | 145 ++++++++++++++
 tb/tb_prbs_test_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_test_ctrl.sv
// Sequencing controller for the PRBS pattern-check datapath: loads a 32-bit
// search pattern, releases the datapath for a bounded run and reports the result.
module prbs_test_ctrl #(
    parameter int SLACK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       n_repeats,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             abort,
    input  logic             pattern_found,
    output logic [31:0]      pattern_word,
    output logic [7:0]       n_rep_q,
    output logic             dp_rst_n,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] found_cycle
);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pattern_q, pattern_d;
    logic [7:0]         nrep_q, nrep_d;
    logic [CNT_W-1:0]   found_q, found_d;
    logic [1:0]         status_q, status_d;
    logic               dprstn_q, dprstn_d;
    logic               done_q, done_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   rcnt_q, rcnt_d;
    logic [CNT_W-1:0]   limit;

    // Run budget is evaluated at counter width so the largest repeat count cannot wrap.
    assign limit = (CNT_W'(nrep_q) << 2) + CNT_W'(SLACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            nrep_q    <= '0;
            found_q   <= '0;
            status_q  <= '0;
            dprstn_q  <= 1'b0;
            done_q    <= 1'b0;
            bcnt_q    <= '0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            nrep_q    <= nrep_d;
            found_q   <= found_d;
            status_q  <= status_d;
            dprstn_q  <= dprstn_d;
            done_q    <= done_d;
            bcnt_q    <= bcnt_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        nrep_d    = nrep_q;
        found_d   = found_q;
        status_d  = status_q;
        bcnt_d    = bcnt_q;
        rcnt_d    = rcnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nrep_d    = n_repeats;
                    pattern_d = '0;
                    found_d   = '0;
                    status_d  = 2'b00;
                    bcnt_d    = '0;
                    if (n_repeats == 8'd0) begin
                        status_d = 2'b11;
                        state_d  = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    status_d = 2'b11;
                    state_d  = DONE;
                end else if (byte_valid) begin
                    case (bcnt_q)
                        2'd0:    pattern_d[31:24] = byte_in;
                        2'd1:    pattern_d[23:16] = byte_in;
                        2'd2:    pattern_d[15:8]  = byte_in;
                        default: pattern_d[7:0]   = byte_in;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) state_d = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    status_d = 2'b11;
                    state_d  = DONE;
                end else begin
                    rcnt_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Priority: abort, then a hit, then the timeout.
                if (abort) begin
                    status_d = 2'b11;
                    state_d  = DONE;
                end else if (pattern_found) begin
                    found_d  = rcnt_q;
                    status_d = 2'b01;
                    state_d  = DONE;
                end else if (rcnt_q == limit - CNT_W'(1)) begin
                    status_d = 2'b10;
                    state_d  = DONE;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dprstn_d = (state_d == RUN);
        done_d   = (state_d == DONE);
    end

    assign byte_ready   = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign pattern_word = pattern_q;
    assign n_rep_q      = nrep_q;
    assign found_cycle  = found_q;
    assign status       = status_q;
    assign dp_rst_n     = dprstn_q;
    assign done         = done_q;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Directed bench for prbs_test_ctrl with a test-level reference model checked
// every cycle, plus literal expectations for the key results.
module tb_prbs_test_ctrl;

    localparam int SLACK = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       n_repeats = '0;
    logic [7:0]       byte_in = '0;
    logic             byte_valid = 1'b0;
    logic             byte_ready;
    logic             abort = 1'b0;
    logic             pattern_found = 1'b0;
    logic [31:0]      pattern_word;
    logic [7:0]       n_rep_q;
    logic             dp_rst_n;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] found_cycle;

    int total = 0;
    int bad = 0;

    prbs_test_ctrl #(.SLACK(SLACK), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_repeats(n_repeats),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .abort(abort), .pattern_found(pattern_found), .pattern_word(pattern_word),
        .n_rep_q(n_rep_q), .dp_rst_n(dp_rst_n), .busy(busy), .done(done),
        .status(status), .found_cycle(found_cycle)
    );

    always #5 clk = ~clk;

    // Reference model: what phase of the test we are in, how many bytes have
    // arrived, and how many cycles the datapath has been running.
    string mPhase = "idle";
    int    mBytes[4];
    int    mGot = 0;
    int    mRep = 0;
    int    mRunIdx = 0;
    int    mFound = 0;
    int    mStat = 0;

    function automatic logic [31:0] expWord();
        return 32'((mBytes[0] * 16777216) + (mBytes[1] * 65536) + (mBytes[2] * 256) + mBytes[3]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase = "idle";
            mGot = 0; mRep = 0; mRunIdx = 0; mFound = 0; mStat = 0;
            for (int i = 0; i < 4; i++) mBytes[i] = 0;
        end else if (mPhase == "idle") begin
            if (start) begin
                mRep = int'(n_repeats);
                mGot = 0; mFound = 0; mStat = 0;
                for (int i = 0; i < 4; i++) mBytes[i] = 0;
                if (mRep == 0) begin mStat = 3; mPhase = "done"; end
                else mPhase = "load";
            end
        end else if (mPhase == "done") begin
            mPhase = "idle";
        end else if (abort) begin
            mStat = 3; mPhase = "done";
        end else if (mPhase == "load") begin
            if (byte_valid) begin
                mBytes[mGot] = int'(byte_in);
                mGot++;
                if (mGot == 4) mPhase = "arm";
            end
        end else if (mPhase == "arm") begin
            mRunIdx = 0; mPhase = "run";
        end else begin
            if (pattern_found) begin
                mFound = mRunIdx; mStat = 1; mPhase = "done";
            end else if (mRunIdx == 4 * mRep + SLACK - 1) begin
                mStat = 2; mPhase = "done";
            end else mRunIdx++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc.pattern_word", int'(pattern_word), int'(expWord()));
        checkOutput("cyc.n_rep_q", int'(n_rep_q), mRep);
        checkOutput("cyc.busy", int'(busy), int'(mPhase != "idle"));
        checkOutput("cyc.byte_ready", int'(byte_ready), int'(mPhase == "load"));
        checkOutput("cyc.dp_rst_n", int'(dp_rst_n), int'(mPhase == "run"));
        checkOutput("cyc.done", int'(done), int'(mPhase == "done"));
        checkOutput("cyc.status", int'(status), mStat);
        checkOutput("cyc.found_cycle", int'(found_cycle), mFound);
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] nRep);
        start = 1'b1;
        n_repeats = nRep;
        tick();
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 3; i >= 0; i--) begin
            byte_in = tmp[8*i +: 8];
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic waitDone(input string name, output int runCycles);
        int budget;
        budget = 2000;
        runCycles = 0;
        while (!done && budget > 0) begin
            if (dp_rst_n) runCycles++;
            tick();
            budget--;
        end
        checkOutput({name, ".done_seen"}, int'(done), 1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".pattern_word"}, int'(pattern_word), 0);
        checkOutput({name, ".n_rep_q"}, int'(n_rep_q), 0);
        checkOutput({name, ".busy"}, int'(busy), 0);
        checkOutput({name, ".dp_rst_n"}, int'(dp_rst_n), 0);
        checkOutput({name, ".done"}, int'(done), 0);
        checkOutput({name, ".status"}, int'(status), 0);
    endtask

    initial begin
        int rc;
        logic [7:0] tb [7];
        logic       tv [7];

        #1;
        checkAllZero("reset");
        #11 rst = 1'b0;
        tick();

        // Normal pass with hit on RUN cycle 5.
        applyStimulus(8'd3);
        sendWord(32'hDEADBEEF);
        checkOutput("pass.word", int'(pattern_word), 32'hDEADBEEF);
        checkOutput("pass.arm_dp", int'(dp_rst_n), 0);
        tick();
        tick(5);
        pattern_found = 1'b1;
        tick();
        pattern_found = 1'b0;
        checkOutput("pass.done", int'(done), 1);
        checkOutput("pass.status", int'(status), 1);
        checkOutput("pass.found", int'(found_cycle), 5);
        checkOutput("pass.dp_low", int'(dp_rst_n), 0);
        tick();

        // Timeout with n=2: 16 run cycles.
        applyStimulus(8'd2);
        sendWord(32'h01020304);
        waitDone("timeout", rc);
        checkOutput("timeout.cycles", rc, 16);
        checkOutput("timeout.status", int'(status), 2);
        checkOutput("timeout.found", int'(found_cycle), 0);
        tick();

        // Throttled bytes; junk on invalid slots and after loading.
        tv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tb = '{8'h11, 8'hAA, 8'hAA, 8'h22, 8'h33, 8'hAA, 8'h44};
        applyStimulus(8'd1);
        for (int i = 0; i < 7; i++) begin
            byte_in = tb[i];
            byte_valid = tv[i];
            tick();
        end
        byte_in = 8'h55;
        byte_valid = 1'b1;
        tick(4);
        checkOutput("throttle.word", int'(pattern_word), 32'h11223344);
        byte_valid = 1'b0;
        waitDone("throttle", rc);
        checkOutput("throttle.status", int'(status), 2);
        tick();

        // Zero repeats.
        applyStimulus(8'd0);
        checkOutput("zero.done", int'(done), 1);
        checkOutput("zero.status", int'(status), 3);
        tick();

        // Abort together with a hit on RUN cycle 3.
        applyStimulus(8'd1);
        sendWord(32'hCAFEF00D);
        tick();
        tick(3);
        abort = 1'b1;
        pattern_found = 1'b1;
        tick();
        abort = 1'b0;
        pattern_found = 1'b0;
        checkOutput("abort.status", int'(status), 3);
        tick();

        // Hit on the final run cycle, stray start mid-run.
        applyStimulus(8'd1);
        sendWord(32'h0BADC0DE);
        tick();
        tick(2);
        start = 1'b1;
        n_repeats = 8'd9;
        tick();
        start = 1'b0;
        tick(8);
        pattern_found = 1'b1;
        tick();
        pattern_found = 1'b0;
        checkOutput("edge.status", int'(status), 1);
        checkOutput("edge.found", int'(found_cycle), 11);
        checkOutput("edge.nrep", int'(n_rep_q), 1);
        tick();
        applyStimulus(8'd4);
        checkOutput("restart.status", int'(status), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Async reset mid-LOAD.
        applyStimulus(8'd2);
        byte_in = 8'h77;
        byte_valid = 1'b1;
        tick(2);
        byte_valid = 1'b0;
        #3 rst = 1'b1;
        #1 checkAllZero("rstload");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Async reset mid-RUN.
        applyStimulus(8'd2);
        sendWord(32'h12345678);
        tick(4);
        #3 rst = 1'b1;
        #1 checkAllZero("rstrun");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Clean test after reset.
        applyStimulus(8'd2);
        sendWord(32'hA5A55A5A);
        tick();
        tick(7);
        pattern_found = 1'b1;
        tick();
        pattern_found = 1'b0;
        checkOutput("clean.status", int'(status), 1);
        checkOutput("clean.found", int'(found_cycle), 7);
        checkOutput("clean.word", int'(pattern_word), 32'hA5A55A5A);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
